// File: rtl/pipe_ctl_pkg.sv
// Shared types and constants for the pipeline interlock/flush controller.
// Imported by pipe_scoreboard and pipe_ctl.
package pipe_ctl_pkg;

    localparam int         SB_DEPTH_DEFAULT = 3;
    localparam logic [4:0] REG_ZERO         = 5'd0;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } pipe_state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] wreg;
    } sb_entry_t;

    // True when a pending write in this entry feeds the given source operand.
    function automatic logic entry_hits(input sb_entry_t  e,
                                        input logic       use_src,
                                        input logic [4:0] src);
        return e.valid && use_src && (e.wreg == src);
    endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// Shift-register scoreboard of pending register writes in EX, MEM and WB,
// with per-stage squash and source-operand match logic.
module pipe_scoreboard
    import pipe_ctl_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  sb_entry_t        push,
    input  logic [DEPTH-1:0] squash_mask,
    input  logic             use_rs,
    input  logic [4:0]       rs,
    input  logic             use_rt,
    input  logic [4:0]       rt,
    output logic             rs_hit,
    output logic             rt_hit
);

    sb_entry_t entries [DEPTH];

    // A set squash bit clears the value about to be loaded into that stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            entries[0] <= squash_mask[0] ? '0 : push;
            for (int i = 1; i < DEPTH; i++) begin
                entries[i] <= squash_mask[i] ? '0 : entries[i-1];
            end
        end
    end

    always_comb begin
        rs_hit = 1'b0;
        rt_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            rs_hit = rs_hit | entry_hits(entries[i], use_rs, rs);
            rt_hit = rt_hit | entry_hits(entries[i], use_rt, rt);
        end
    end

endmodule

// File: rtl/pipe_ctl.sv
// Interlock and flush controller for the five-stage MIPS pipeline (no forwarding).
// Define PIPE_CTL_STATS_EN to build the stall-cycle and flush counters.
module pipe_ctl
    import pipe_ctl_pkg::*;
#(
    parameter int SB_DEPTH = SB_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        id_regwrite,
    input  logic [4:0]  id_wrreg,
    input  logic        mem_branch_taken,
    output logic        pc_stall,
    output logic        ifid_stall,
    output logic        idex_bubble,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic        flush_exmem,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    pipe_state_t         state;
    sb_entry_t           push;
    logic [SB_DEPTH-1:0] squash_mask;
    logic                rs_hit;
    logic                rt_hit;
    logic                hazard;
    logic                do_stall;
    logic                do_flush;

    pipe_scoreboard #(
        .DEPTH(SB_DEPTH)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .squash_mask(squash_mask),
        .use_rs     (id_use_rs),
        .rs         (id_rs),
        .use_rt     (id_use_rt),
        .rt         (id_rt),
        .rs_hit     (rs_hit),
        .rt_hit     (rt_hit)
    );

    // Flush wins over stall; reset silences every control output.
    assign hazard   = id_valid && (state != FLUSH) && (rs_hit || rt_hit);
    assign do_flush = !reset && mem_branch_taken;
    assign do_stall = !reset && hazard && !mem_branch_taken;

    always_comb begin
        push = '0;
        if (!do_stall && !do_flush) begin
            push.valid = id_valid && id_regwrite && (id_wrreg != REG_ZERO);
            push.wreg  = id_wrreg;
        end
    end

    // On a flush the ID and EX instructions are squashed; MEM advances to WB.
    always_comb begin
        squash_mask = '0;
        if (do_flush) begin
            squash_mask = SB_DEPTH'(3);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else if (mem_branch_taken) begin
            state <= FLUSH;
        end else begin
            case (state)
                RUN:     state <= hazard ? STALL : RUN;
                STALL:   state <= hazard ? STALL : RUN;
                FLUSH:   state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    assign pc_stall    = do_stall;
    assign ifid_stall  = do_stall;
    assign idex_bubble = do_stall;
    assign flush_ifid  = do_flush;
    assign flush_idex  = do_flush;
    assign flush_exmem = do_flush;

`ifdef PIPE_CTL_STATS_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (do_stall) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (mem_branch_taken) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cnt;
    assign flush_count  = flush_cnt;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctl.sv
// Self-checking bench for pipe_ctl: directed hazard/flush/reset scenarios plus
// randomized traffic checked against an issue-history reference model.
module tb_pipe_ctl;

    localparam int SB_DEPTH = 3;
`ifdef PIPE_CTL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_use_rs;
    logic        id_use_rt;
    logic        id_regwrite;
    logic [4:0]  id_wrreg;
    logic        mem_branch_taken;
    logic        pc_stall;
    logic        ifid_stall;
    logic        idex_bubble;
    logic        flush_ifid;
    logic        flush_idex;
    logic        flush_exmem;
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;

    pipe_ctl #(
        .SB_DEPTH(SB_DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .id_valid        (id_valid),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_use_rs       (id_use_rs),
        .id_use_rt       (id_use_rt),
        .id_regwrite     (id_regwrite),
        .id_wrreg        (id_wrreg),
        .mem_branch_taken(mem_branch_taken),
        .pc_stall        (pc_stall),
        .ifid_stall      (ifid_stall),
        .idex_bubble     (idex_bubble),
        .flush_ifid      (flush_ifid),
        .flush_idex      (flush_idex),
        .flush_exmem     (flush_exmem),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
    );

    always #5 clk = ~clk;

    // Reference model: every issued register write with the cycle it left ID.
    // A write issued in cycle c is visible to a reader in cycle c+SB_DEPTH+1.
    typedef struct {
        logic [4:0] rd;
        int         cyc;
    } issue_t;

    issue_t      pending[$];
    int          now = 0;
    bit          prev_flush = 1'b0;
    logic [31:0] exp_stalls = '0;
    logic [31:0] exp_flushes = '0;
    int          stall_run = 0;
    int          obs_stall_total = 0;
    int          compared = 0;
    int          mismatched = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, now);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic urs, input logic urt, input logic rw,
                                 input logic [4:0] wr, input logic mbt, input logic rst);
        logic hz;
        logic e_stall;
        logic e_flush;
        @(negedge clk);
        reset = rst; id_valid = v; id_rs = rs; id_rt = rt;
        id_use_rs = urs; id_use_rt = urt; id_regwrite = rw; id_wrreg = wr;
        mem_branch_taken = mbt;
        #1;
        hz = 1'b0;
        if (!rst && v && !prev_flush) begin
            foreach (pending[i]) begin
                if ((now - pending[i].cyc <= SB_DEPTH) &&
                    ((urs && rs == pending[i].rd) || (urt && rt == pending[i].rd)))
                    hz = 1'b1;
            end
        end
        e_flush = !rst && mbt;
        e_stall = hz && !mbt;
        checkOutput("pc_stall", pc_stall, e_stall);
        checkOutput("ifid_stall", ifid_stall, e_stall);
        checkOutput("idex_bubble", idex_bubble, e_stall);
        checkOutput("flush_ifid", flush_ifid, e_flush);
        checkOutput("flush_idex", flush_idex, e_flush);
        checkOutput("flush_exmem", flush_exmem, e_flush);
        checkOutput("stall_cycles", stall_cycles, STATS ? exp_stalls : 32'd0);
        checkOutput("flush_count", flush_count, STATS ? exp_flushes : 32'd0);
        if (pc_stall === 1'b1) begin
            stall_run++;
            obs_stall_total++;
        end else begin
            stall_run = 0;
        end
        checkOutput("stall_run_bound", 32'(stall_run <= SB_DEPTH), 32'd1);

        // Advance the model to the state after the coming posedge.
        if (rst) begin
            pending.delete();
            prev_flush = 1'b0;
            exp_stalls = '0;
            exp_flushes = '0;
        end else begin
            if (e_flush) begin
                for (int i = pending.size() - 1; i >= 0; i--) begin
                    if (pending[i].cyc == now - 1) pending.delete(i);
                end
            end else if (!e_stall && v && rw && wr != 5'd0) begin
                pending.push_back('{rd: wr, cyc: now});
            end
            if (e_stall) exp_stalls = exp_stalls + 32'd1;
            if (mbt) exp_flushes = exp_flushes + 32'd1;
            prev_flush = e_flush;
        end
        for (int i = pending.size() - 1; i >= 0; i--) begin
            if (now + 1 - pending[i].cyc > SB_DEPTH) pending.delete(i);
        end
        now++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int base;
        reset = 1'b1; id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0;
        id_use_rt = 0; id_regwrite = 0; id_wrreg = 0; mem_branch_taken = 0;
        repeat (2) @(posedge clk);

        // Reset with junk inputs, then a reader right after: no stall.
        applyStimulus(1, 5'd3, 5'd4, 1, 1, 1, 5'd3, 1, 1);
        applyStimulus(1, 5'd5, 5'd0, 1, 0, 0, 5'd0, 0, 0);
        checkOutput("post_reset_no_stall", pc_stall, 0);
        idle(4);

        // add $3 then sub $4,$3,$1 held in ID while stalled: exactly 3 stalls.
        base = obs_stall_total;
        applyStimulus(1, 5'd1, 5'd2, 1, 1, 1, 5'd3, 0, 0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 5'd3, 5'd1, 1, 1, 1, 5'd4, 0, 0);
            if (pc_stall !== 1'b1) break;
        end
        checkOutput("b2b_stall_len", obs_stall_total - base, 3);
        idle(4);
        checkOutput("b2b_stall_cycles", stall_cycles, STATS ? 32'd3 : 32'd0);

        // One independent instruction between producer and consumer: 2 stalls.
        base = obs_stall_total;
        applyStimulus(1, 5'd1, 5'd2, 1, 1, 1, 5'd5, 0, 0);
        applyStimulus(1, 5'd1, 5'd2, 1, 1, 1, 5'd6, 0, 0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 5'd5, 5'd2, 1, 1, 1, 5'd7, 0, 0);
            if (pc_stall !== 1'b1) break;
        end
        checkOutput("gap1_stall_len", obs_stall_total - base, 2);
        idle(4);

        // Write to $0 then read $0: never a hazard.
        base = obs_stall_total;
        applyStimulus(1, 5'd1, 5'd2, 1, 1, 1, 5'd0, 0, 0);
        applyStimulus(1, 5'd0, 5'd0, 1, 1, 1, 5'd8, 0, 0);
        checkOutput("zero_reg_stalls", obs_stall_total - base, 0);
        idle(4);

        // Pending stall on $3 meets a taken branch; the squashed EX write is gone.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 5'd1, 5'd2, 1, 1, 1, 5'd3, 0, 0);
        applyStimulus(1, 5'd3, 5'd1, 1, 1, 1, 5'd4, 1, 0);
        checkOutput("flush_prio_exmem", flush_exmem, 1);
        checkOutput("flush_prio_stall", pc_stall, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 5'd3, 5'd1, 1, 1, 1, 5'd4, 0, 0);
        checkOutput("squashed_no_stall", pc_stall, 0);
        checkOutput("flush_count_one", flush_count, STATS ? 32'd1 : 32'd0);
        idle(4);

        // Reset after one of three stall cycles; consumer then issues freely.
        base = obs_stall_total;
        applyStimulus(1, 5'd1, 5'd2, 1, 1, 1, 5'd3, 0, 0);
        applyStimulus(1, 5'd3, 5'd1, 1, 1, 1, 5'd4, 0, 0);
        applyStimulus(1, 5'd3, 5'd1, 1, 1, 1, 5'd4, 0, 1);
        applyStimulus(1, 5'd3, 5'd1, 1, 1, 1, 5'd4, 0, 0);
        checkOutput("reset_mid_stall_len", obs_stall_total - base, 1);
        checkOutput("reset_mid_stall_cnt", stall_cycles, 0);
        idle(2);

        // Randomized traffic over a small register set to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0),
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                          1'($urandom_range(0, 11) == 0),
                          1'($urandom_range(0, 79) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
